// File: rtl/enc_fns_seq.sv
// enc_fns_seq: sequential Fibonacci-numeral-system encoder.
// A data word is converted to a 9-bit forbidden-transition codeword.
// It resolves one code bit per cycle, greedy and MSB-first, using runtime weights.
// Optional feature macro: ENC_FNS_EARLY_EN. When it is defined, encoding stops
// as soon as the residual reaches zero.
module enc_fns_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WGT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datain,
    input  logic [8:0]        en_flag,
    input  logic [WGT_W-1:0]  FNS03,
    input  logic [WGT_W-1:0]  FNS04,
    input  logic [WGT_W-1:0]  FNS05,
    input  logic [WGT_W-1:0]  FNS06,
    input  logic [WGT_W-1:0]  FNS07,
    input  logic [WGT_W-1:0]  FNS08,
    input  logic [WGT_W-1:0]  FNS09,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        codeout,
    output logic              enc_err
);

    localparam int unsigned RES_W  = ((DATA_W > WGT_W) ? DATA_W : WGT_W) + 1;
    localparam int unsigned K_W    = 4;
    localparam int unsigned WVEC_W = 7 * WGT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [8:0]         code_q, code_d;
    logic [8:0]         en_q, en_d;
    logic [WVEC_W-1:0]  wgt_q, wgt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               enc_err_q, enc_err_d;
    logic [RES_W-1:0]   cur_w_c;
    logic               early_c;

    // Weight of the bit currently being resolved (bits 0 and 1 weigh 1)
    always_comb begin
        cur_w_c = RES_W'(1);
        for (int i = 2; i < 9; i++) begin
            if (k_q == K_W'(i)) begin
                cur_w_c = RES_W'(wgt_q[(i-2)*WGT_W +: WGT_W]);
            end
        end
    end

`ifdef ENC_FNS_EARLY_EN
    // Nothing left to encode: the remaining bits stay 0
    assign early_c = (res_q == '0);
`else
    assign early_c = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        res_d     = res_q;
        code_d    = code_q;
        en_d      = en_q;
        wgt_d     = wgt_q;
        enc_err_d = enc_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    res_d     = RES_W'(datain);
                    en_d      = en_flag;
                    wgt_d     = {FNS09, FNS08, FNS07, FNS06, FNS05, FNS04, FNS03};
                    code_d    = '0;
                    enc_err_d = 1'b0;
                    k_d       = K_W'(8);
                    state_d   = S_ENC;
                end
            end
            S_ENC: begin
                if (early_c) begin
                    enc_err_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    // The compare gates the subtraction, so it cannot underflow
                    if (en_q[k_q] && (res_q >= cur_w_c)) begin
                        code_d[k_q] = 1'b1;
                        res_d       = res_q - cur_w_c;
                    end
                    if (k_q == '0) begin
                        enc_err_d = (res_d != '0);
                        state_d   = S_DONE;
                    end else begin
                        k_d = k_q - K_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= K_W'(8);
            res_q       <= '0;
            code_q      <= '0;
            en_q        <= '0;
            wgt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            enc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            res_q       <= res_d;
            code_q      <= code_d;
            en_q        <= en_d;
            wgt_q       <= wgt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            enc_err_q   <= enc_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign codeout   = code_q;
    assign enc_err   = enc_err_q;

endmodule

// File: tb/tb_enc_fns_seq.sv
// Self-checking bench for enc_fns_seq.
// It uses spec vectors, hand-written corner sequences and randomized words.
// The randomized words are checked against a greedy arithmetic reference model.
module tb_enc_fns_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] datain;
    logic [8:0] en_flag;
    logic [7:0] FNS03, FNS04, FNS05, FNS06, FNS07, FNS08, FNS09;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] codeout;
    logic       enc_err;

    int n_checks = 0;
    int n_fail   = 0;
    int wt[9];

    enc_fns_seq #(.DATA_W(8), .WGT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .datain(datain), .en_flag(en_flag),
        .FNS03(FNS03), .FNS04(FNS04), .FNS05(FNS05), .FNS06(FNS06),
        .FNS07(FNS07), .FNS08(FNS08), .FNS09(FNS09),
        .out_valid(out_valid), .out_ready(out_ready),
        .codeout(codeout), .enc_err(enc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Greedy MSB-first reference built from plain integer arithmetic
    function automatic void model(input int d, input logic [8:0] en,
                                  output logic [8:0] code, output logic err,
                                  output int lat);
        int r;
        r    = d;
        code = '0;
        lat  = 0;
        for (int k = 8; k >= 0; k--) begin
            lat++;
`ifdef ENC_FNS_EARLY_EN
            if (r == 0) break;
`endif
            if (en[k] && r >= wt[k]) begin
                code[k] = 1'b1;
                r       = r - wt[k];
            end
        end
        err = (r != 0);
    endfunction

    task automatic drive_weights();
        FNS03 = 8'(wt[2]); FNS04 = 8'(wt[3]); FNS05 = 8'(wt[4]);
        FNS06 = 8'(wt[5]); FNS07 = 8'(wt[6]); FNS08 = 8'(wt[7]);
        FNS09 = 8'(wt[8]);
    endtask

    task automatic scramble_inputs();
        datain  = 8'($urandom);
        en_flag = 9'($urandom);
        FNS03 = 8'($urandom); FNS04 = 8'($urandom); FNS05 = 8'($urandom);
        FNS06 = 8'($urandom); FNS07 = 8'($urandom); FNS08 = 8'($urandom);
        FNS09 = 8'($urandom);
    endtask

    // Send one word, collect the codeword, stall 'hold' cycles, then hand off
    task automatic run_word(input int d, input logic [8:0] en, input int hold,
                            output logic [8:0] code, output logic err, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid  = 1'b1;
        datain    = 8'(d);
        en_flag   = en;
        drive_weights();
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        code = codeout;
        err  = enc_err;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            datain   = 8'd88;
            @(posedge clk); #1;
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_codeout", int'(codeout), int'(code));
            chk("hold_enc_err", int'(enc_err), int'(err));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff_out_valid", int'(out_valid), 0);
        chk("handoff_in_ready", int'(in_ready), 1);
    endtask

    typedef struct {
        int         d;
        logic [8:0] en;
        logic [8:0] code;
        logic       err;
    } vec_t;

    vec_t       vecs[6];
    logic [8:0] got_code, exp_code;
    logic       got_err, exp_err;
    int         got_lat, exp_lat;

    initial begin
        vecs[0] = '{d: 7,  en: 9'h1FF, code: 9'h014, err: 1'b0};
        vecs[1] = '{d: 33, en: 9'h1FF, code: 9'h0AA, err: 1'b0};
        vecs[2] = '{d: 88, en: 9'h1FF, code: 9'h1FF, err: 1'b0};
        vecs[3] = '{d: 0,  en: 9'h1FF, code: 9'h000, err: 1'b0};
        vecs[4] = '{d: 88, en: 9'h0FF, code: 9'h0FF, err: 1'b1};
        vecs[5] = '{d: 34, en: 9'h1FF, code: 9'h100, err: 1'b0};
        wt = '{1, 1, 2, 3, 5, 8, 13, 21, 34};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        datain = '0; en_flag = '0; drive_weights();
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_codeout", int'(codeout), 0);
        chk("rst_enc_err", int'(enc_err), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", int'(in_ready), 1);

        // Spec vectors with standard weights
        foreach (vecs[i]) begin
            run_word(vecs[i].d, vecs[i].en, 0, got_code, got_err, got_lat);
            model(vecs[i].d, vecs[i].en, exp_code, exp_err, exp_lat);
            chk($sformatf("vec%0d_code", i), int'(got_code), int'(vecs[i].code));
            chk($sformatf("vec%0d_err", i), int'(got_err), int'(vecs[i].err));
            chk($sformatf("vec%0d_lat", i), got_lat, exp_lat);
        end

        // Datain 34 latency: 2 cycles with early exit, 9 without
`ifdef ENC_FNS_EARLY_EN
        run_word(34, 9'h1FF, 0, got_code, got_err, got_lat);
        chk("d34_lat", got_lat, 2);
`else
        run_word(34, 9'h1FF, 0, got_code, got_err, got_lat);
        chk("d34_lat", got_lat, 9);
`endif
        chk("d34_code", int'(got_code), 'h100);

        // Back-pressure: hold 5 cycles with in_valid pulses, then the next word must be clean
        run_word(33, 9'h1FF, 5, got_code, got_err, got_lat);
        chk("stall_code", int'(got_code), 'h0AA);
        run_word(7, 9'h1FF, 0, got_code, got_err, got_lat);
        chk("after_stall_code", int'(got_code), 'h014);

        // Reset in the middle of encoding, when k=4
        in_valid = 1'b1; datain = 8'd88; en_flag = 9'h1FF; drive_weights();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_codeout", int'(codeout), 0);
        chk("midrst_enc_err", int'(enc_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_word(7, 9'h1FF, 0, got_code, got_err, got_lat);
        chk("postrst_code", int'(got_code), 'h014);
        chk("postrst_err", int'(got_err), 0);

        // Randomized words: standard or arbitrary weights, random enables
        for (int t = 0; t < 40; t++) begin
            int         d;
            logic [8:0] en;
            if (t % 2 == 0) begin
                wt = '{1, 1, 2, 3, 5, 8, 13, 21, 34};
                d  = int'($urandom_range(0, 88));
            end else begin
                for (int k = 2; k < 9; k++) wt[k] = int'($urandom_range(1, 255));
                d = int'($urandom_range(0, 255));
            end
            en = ($urandom_range(0, 1) == 1) ? 9'h1FF : 9'($urandom);
            run_word(d, en, int'($urandom_range(0, 2)), got_code, got_err, got_lat);
            model(d, en, exp_code, exp_err, exp_lat);
            chk($sformatf("rnd%0d_code", t), int'(got_code), int'(exp_code));
            chk($sformatf("rnd%0d_err", t), int'(got_err), int'(exp_err));
            chk($sformatf("rnd%0d_lat", t), got_lat, exp_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
